// File: rtl/aes_gcm_stream_if_if.sv
// Word-serial stream bundle for the AES-128-GCM front/back end.
// Both channels use the same handshake: a word moves on a rising edge where valid && ready.
interface gcm_stream_bus;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [1:0]  s_type;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_type;
  logic        m_last;
  logic        err;
  logic [1:0]  fsm_state;

  modport slave (
    input  s_valid, s_data, s_type, s_last, m_ready,
    output s_ready, m_valid, m_data, m_type, m_last, err, fsm_state
  );
  modport master (
    output s_valid, s_data, s_type, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_type, m_last, err, fsm_state
  );
endinterface

// File: rtl/aes_gcm_stream_if.sv
// Collects key/iv/aad/pt words, holds a combinational AES-128-GCM core stable for
// CALC_CYCLES cycles, then streams ciphertext and tag out as 32-bit words.
module aes_gcm_stream_if #(
  parameter int CALC_CYCLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  gcm_stream_bus.slave bus
);
  typedef enum logic [1:0] {LOAD = 2'd0, COMPUTE = 2'd1, OUTPUT = 2'd2} state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as x^254 (field inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, p;
    y = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) y = gf8_mul(y, p);
      p = gf8_mul(p, p);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  t;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = blk ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) u[4*c+k] = s[4*((c+k)%4)+k];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = u[i];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // GF(2^128) multiply in GCM's reflected bit order.
  function automatic logic [127:0] ghash_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 127; i >= 0; i--) begin
      if (x[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  state_t       state;
  logic [127:0] key_r, aad_r, pt_r, ct_q, tag_q;
  logic [95:0]  iv_r;
  logic [2:0]   key_cnt, iv_cnt, aad_cnt, pt_cnt, out_idx, nxt_idx;
  logic [1:0]   cur_type;
  logic         aad_valid, pt_valid;
  logic [15:0]  wait_cnt;
  logic         s_ready_q, m_valid_q, m_type_q, m_last_q, err_q;
  logic [31:0]  m_data_q;

  // Core: combinational from the frame registers only.
  logic [127:0] h_key, ek_j0, ct_c, x_aad, x_ct, tag_c;
  assign h_key = aes_enc(key_r, 128'h0);
  assign ek_j0 = aes_enc(key_r, {iv_r, 32'd1});
  assign ct_c  = pt_r ^ aes_enc(key_r, {iv_r, 32'd2});
  assign x_aad = aad_valid ? ghash_mul(aad_r, h_key) : 128'h0;
  assign x_ct  = pt_valid ? ghash_mul(x_aad ^ ct_c, h_key) : x_aad;
  assign tag_c = ek_j0 ^ ghash_mul(x_ct ^ {(aad_valid ? 64'd128 : 64'd0),
                                           (pt_valid ? 64'd128 : 64'd0)}, h_key);

  // Counts as they would be after accepting the current word, and the frame checks.
  logic [2:0] key_n, iv_n, aad_n, pt_n, fcnt, cap;
  logic       last_ok, bad;
  always_comb begin
    key_n = key_cnt + {2'b0, bus.s_type == 2'd0};
    iv_n  = iv_cnt  + {2'b0, bus.s_type == 2'd1};
    aad_n = aad_cnt + {2'b0, bus.s_type == 2'd2};
    pt_n  = pt_cnt  + {2'b0, bus.s_type == 2'd3};
    fcnt  = key_cnt;
    cap   = 3'd4;
    case (bus.s_type)
      2'd1:    begin fcnt = iv_cnt;  cap = 3'd3; end
      2'd2:    fcnt = aad_cnt;
      2'd3:    fcnt = pt_cnt;
      default: fcnt = key_cnt;
    endcase
    last_ok = (key_n == 3'd4) && (iv_n == 3'd3) &&
              (aad_n == 3'd0 || aad_n == 3'd4) && (pt_n == 3'd0 || pt_n == 3'd4);
    bad     = (bus.s_type < cur_type) || (fcnt == cap) || (bus.s_last && !last_ok);
  end

  function automatic logic [31:0] out_word(input logic [2:0] idx, input logic [127:0] ct,
                                           input logic [127:0] tg);
    logic [127:0] sel;
    sel = idx[2] ? tg : ct;
    return sel[127 - 32*idx[1:0] -: 32];
  endfunction

  assign nxt_idx = out_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      key_r <= '0; iv_r <= '0; aad_r <= '0; pt_r <= '0; ct_q <= '0; tag_q <= '0;
      key_cnt <= '0; iv_cnt <= '0; aad_cnt <= '0; pt_cnt <= '0; cur_type <= '0;
      aad_valid <= 1'b0; pt_valid <= 1'b0; wait_cnt <= '0; out_idx <= '0;
      s_ready_q <= 1'b0; m_valid_q <= 1'b0; m_data_q <= '0; m_type_q <= 1'b0;
      m_last_q <= 1'b0; err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        LOAD: begin
          s_ready_q <= 1'b1;
          if (bus.s_valid && s_ready_q) begin
            if (bad) begin
              err_q <= 1'b1;
              key_cnt <= '0; iv_cnt <= '0; aad_cnt <= '0; pt_cnt <= '0;
              cur_type <= '0; aad_valid <= 1'b0; pt_valid <= 1'b0;
            end else begin
              case (bus.s_type)
                2'd0:    key_r <= {key_r[95:0], bus.s_data};
                2'd1:    iv_r  <= {iv_r[63:0], bus.s_data};
                2'd2:    aad_r <= {aad_r[95:0], bus.s_data};
                default: pt_r  <= {pt_r[95:0], bus.s_data};
              endcase
              key_cnt <= key_n; iv_cnt <= iv_n; aad_cnt <= aad_n; pt_cnt <= pt_n;
              cur_type <= bus.s_type;
              if (bus.s_last) begin
                aad_valid <= (aad_n == 3'd4);
                pt_valid  <= (pt_n == 3'd4);
                wait_cnt  <= 16'(CALC_CYCLES - 1);
                s_ready_q <= 1'b0;
                state     <= COMPUTE;
              end
            end
          end
        end
        COMPUTE: begin
          if (wait_cnt == 16'd0) begin
            ct_q    <= ct_c;
            tag_q   <= tag_c;
            out_idx <= pt_valid ? 3'd0 : 3'd4;
            state   <= OUTPUT;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        OUTPUT: begin
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_data_q  <= out_word(out_idx, ct_q, tag_q);
            m_type_q  <= out_idx[2];
            m_last_q  <= (out_idx == 3'd7);
          end else if (bus.m_ready) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              s_ready_q <= 1'b1;
              key_cnt <= '0; iv_cnt <= '0; aad_cnt <= '0; pt_cnt <= '0;
              cur_type <= '0; aad_valid <= 1'b0; pt_valid <= 1'b0;
              state <= LOAD;
            end else begin
              out_idx  <= nxt_idx;
              m_data_q <= out_word(nxt_idx, ct_q, tag_q);
              m_type_q <= nxt_idx[2];
              m_last_q <= (nxt_idx == 3'd7);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_type    = m_type_q;
  assign bus.m_last    = m_last_q;
  assign bus.err       = err_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_aes_gcm_stream_if.sv
// Directed bench for aes_gcm_stream_if: known GCM vectors, protocol errors, resets, stalls.
module tb_aes_gcm_stream_if;
  localparam int CALC = 4;
  localparam logic [127:0] T1_TAG = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] T2_CT  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T2_TAG = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] H_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] AAD6   = 128'hfeedfacedeadbeeffeedfacedeadbeef;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcm_stream_bus bus();
  aes_gcm_stream_if #(.CALC_CYCLES(CALC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z, v;
    z = '0;
    v = a;
    for (int i = 127; i >= 0; i--) begin
      if (b[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  task automatic push128(input logic [127:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[127-32*i -: 32]);
  endtask

  task automatic send_word(input logic [1:0] t, input logic [31:0] d, input logic l);
    int n;
    bus.s_valid = 1'b1; bus.s_type = t; bus.s_data = d; bus.s_last = l;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("s_ready_wait", bus.s_ready, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic send_words(input logic [1:0] t, input logic [127:0] d, input int nw, input bit last);
    for (int i = 0; i < nw; i++) send_word(t, d[127-32*i -: 32], last && (i == nw - 1));
  endtask

  task automatic send_frame(input logic [127:0] key, input logic [95:0] iv,
                            input bit has_aad, input logic [127:0] aad,
                            input bit has_pt, input logic [127:0] pt);
    send_words(2'd0, key, 4, 1'b0);
    send_words(2'd1, {iv, 32'h0}, 3, !has_aad && !has_pt);
    if (has_aad) send_words(2'd2, aad, 4, !has_pt);
    if (has_pt)  send_words(2'd3, pt, 4, 1'b1);
  endtask

  // Receive up to 'take' of 'nw' expected words; optional random back-pressure.
  task automatic recv(input int nw, input int take, input bit rnd, output int lat);
    int got, cyc;
    bit stalled;
    logic [31:0] held, exp_w;
    lat = 0;
    while (bus.m_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("m_valid_seen", bus.m_valid, 1);
    got = 0; cyc = 0; stalled = 0; held = '0;
    while (got < take && cyc < 400) begin
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) check("m_data_stable", bus.m_data, held);
      if (bus.m_valid && bus.m_ready) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check("m_data", bus.m_data, exp_w);
        check("m_type", bus.m_type, got >= nw - 4);
        check("m_last", bus.m_last, got == nw - 1);
        got++;
        stalled = 0;
      end else if (bus.m_valid) begin
        stalled = 1;
        held = bus.m_data;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.m_ready = 1'b0;
    check("words_received", got, take);
    if (take == nw) begin
      check("m_valid_after_last", bus.m_valid, 0);
      check("s_ready_after_last", bus.s_ready, 1);
    end
  endtask

  task automatic expect_err_pulse(input string tag);
    check({tag, "_err"}, bus.err, 1);
    @(posedge clk); #1;
    check({tag, "_err_clear"}, bus.err, 0);
    repeat (CALC + 3) @(posedge clk);
    #1;
    check({tag, "_no_output"}, bus.m_valid, 0);
    check({tag, "_load"}, bus.fsm_state, 2'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_ready", bus.s_ready, 1);
    check("post_rst_load", bus.fsm_state, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] t6_tag, x;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_type = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;

    // Reset values
    #1;
    check("reset_s_ready", bus.s_ready, 0);
    check("reset_m_valid", bus.m_valid, 0);
    check("reset_m_data", bus.m_data, 0);
    check("reset_m_type", bus.m_type, 0);
    check("reset_m_last", bus.m_last, 0);
    check("reset_err", bus.err, 0);
    check("reset_state", bus.fsm_state, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_s_ready", bus.s_ready, 1);

    // T1: empty frame
    send_frame('0, '0, 0, '0, 0, '0);
    check("t1_no_err", bus.err, 0);
    push128(T1_TAG);
    recv(4, 4, 0, lat);
    check("t1_latency", lat, CALC + 1);

    // T2: one zero PT block
    send_frame('0, '0, 0, '0, 1, '0);
    check("t2_no_err", bus.err, 0);
    push128(T2_CT); push128(T2_TAG);
    recv(8, 8, 0, lat);
    check("t2_latency", lat, CALC + 1);

    // T3: same frame with random back-pressure
    send_frame('0, '0, 0, '0, 1, '0);
    push128(T2_CT); push128(T2_TAG);
    recv(8, 8, 1, lat);

    // T4a: iv incomplete when the frame ends on pt
    send_words(2'd0, '0, 4, 1'b0);
    send_words(2'd1, '0, 2, 1'b0);
    check("t4a_no_early_err", bus.err, 0);
    send_words(2'd3, '0, 4, 1'b1);
    expect_err_pulse("t4a");
    // T4b: last after 2 aad words
    send_words(2'd0, '0, 4, 1'b0);
    send_words(2'd1, '0, 3, 1'b0);
    send_words(2'd2, AAD6, 2, 1'b1);
    expect_err_pulse("t4b");
    // T4c: fifth key word
    send_words(2'd0, '0, 4, 1'b0);
    send_word(2'd0, 32'h0, 1'b0);
    expect_err_pulse("t4c");
    send_frame('0, '0, 0, '0, 0, '0);
    push128(T1_TAG);
    recv(4, 4, 0, lat);

    // T5: reset during COMPUTE, then after three output words
    send_frame('0, '0, 0, '0, 1, '0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_compute", bus.fsm_state, 2'd1);
    do_reset();
    send_frame('0, '0, 0, '0, 1, '0);
    push128(T2_CT); push128(T2_TAG);
    recv(8, 3, 0, lat);
    check("t5_mid_output_valid", bus.m_valid, 1);
    exp_q.delete();
    do_reset();
    send_frame('0, '0, 0, '0, 1, '0);
    push128(T2_CT); push128(T2_TAG);
    recv(8, 8, 0, lat);

    // T6: AAD-only frame, tag from the GHASH model on the zero-key subkey
    x = gf_mul(AAD6, H_ZERO);
    x = gf_mul(x ^ {64'd128, 64'd0}, H_ZERO);
    t6_tag = T1_TAG ^ x;
    send_frame('0, '0, 1, AAD6, 0, '0);
    push128(t6_tag);
    recv(4, 4, 0, lat);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
